// File: rtl/param_pkg.sv
// Shared definitions for the force-field parameter RAM, its runtime loader and the host-side model.
package param_pkg;
    localparam int ADDR_W         = 10;
    localparam int WORD_W         = 260;
    localparam int BYTES_PER_WORD = (WORD_W + 7) / 8;

    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_CLEAR = 8'h5A;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        COUNT   = 3'd3,
        DATA    = 3'd4,
        CSUM    = 3'd5
    } state_t;
endpackage

// File: rtl/param_ram_loader.sv
// Parses host write frames from a byte stream and emits one RAM write strobe per assembled
// 260-bit parameter word, at an auto-incrementing address.
module param_ram_loader
    import param_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_csum,
    output logic              err_cmd
);
    localparam int ASM_W = WORD_W - 8;
    localparam logic [5:0] LAST_BYTE = 6'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        word_idx_q, word_idx_d;
    logic [5:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_csum_q, err_csum_d;
    logic              err_cmd_q, err_cmd_d;
    logic              accept;

    // The cycle carrying a write strobe is the single bubble per word.
    assign in_ready = ~wr_en_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_csum_d = err_csum_q;
        err_cmd_d  = err_cmd_q;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (in_data == CMD_WRITE) begin
                        state_d = ADDR_HI;
                        csum_d  = 8'h00;
                    end else if (in_data == CMD_CLEAR) begin
                        err_csum_d = 1'b0;
                        err_cmd_d  = 1'b0;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                ADDR_HI: begin
                    addr_d  = {in_data[ADDR_W-9:0], addr_q[7:0]};
                    csum_d  = csum_q ^ in_data;
                    state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_d  = {addr_q[ADDR_W-1:8], in_data};
                    csum_d  = csum_q ^ in_data;
                    state_d = COUNT;
                end
                COUNT: begin
                    count_d    = in_data;
                    word_idx_d = 8'd0;
                    byte_cnt_d = 6'd0;
                    csum_d     = csum_q ^ in_data;
                    state_d    = DATA;
                end
                DATA: begin
                    // 32 shifts through a 252-bit register drop the first byte's upper nibble.
                    asm_d  = {asm_q[ASM_W-9:0], in_data};
                    csum_d = csum_q ^ in_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = {asm_q, in_data};
                        addr_d     = addr_q + 1'b1;
                        byte_cnt_d = 6'd0;
                        word_idx_d = word_idx_q + 8'd1;
                        if (word_idx_q == count_q) state_d = CSUM;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
                CSUM: begin
                    done_d  = 1'b1;
                    if (in_data != csum_q) err_csum_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_csum_q <= 1'b0;
            err_cmd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_csum_q <= err_csum_d;
            err_cmd_q  <= err_cmd_d;
        end
    end

    // NOTE: the assembly register is fully overwritten before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err_csum = err_csum_q;
    assign err_cmd  = err_cmd_q;
endmodule

// File: tb/tb_param_ram_loader.sv
// Self-checking bench for param_ram_loader: frames are built from random words, and expected
// writes come straight from the words and the start address.
module tb_param_ram_loader;
    import param_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err_csum;
    logic              err_cmd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        frame_q[$];
    logic [WORD_W-1:0] words_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [WORD_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] cap_addr_q[$];
    logic [WORD_W-1:0] cap_data_q[$];
    logic [WORD_W-1:0] gapless_data_q[$];
    int                done_cnt = 0;
    int                done_start = 0;
    int                bubble_viol = 0;

    param_ram_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err_csum (err_csum),
        .err_cmd  (err_cmd)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: capture writes, count done pulses, check the bubble.
    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr_q.push_back(wr_addr);
            cap_data_q.push_back(wr_data);
            if (in_ready) bubble_viol++;
        end
        if (done) done_cnt++;
    end

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < 9; k++) w = {w[WORD_W-33:0], 32'($urandom)};
        return w;
    endfunction

    // Build a write frame from words_q; junk != 0 randomises the ignored header/nibble bits.
    task automatic make_frame(input logic [ADDR_W-1:0] a, input int junk, input int csum_ovr);
        logic [7:0]   hi, lo, cnt, cs, b;
        logic [263:0] w;
        frame_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        hi  = {6'(junk != 0 ? $urandom_range(63) : 0), a[9:8]};
        lo  = a[7:0];
        cnt = 8'(words_q.size() - 1);
        cs  = hi ^ lo ^ cnt;
        frame_q.push_back(CMD_WRITE);
        frame_q.push_back(hi);
        frame_q.push_back(lo);
        frame_q.push_back(cnt);
        for (int i = 0; i < words_q.size(); i++) begin
            w = {4'(junk != 0 ? $urandom_range(15) : 0), words_q[i]};
            for (int k = 32; k >= 0; k--) begin
                b = w[k*8 +: 8];
                frame_q.push_back(b);
                cs ^= b;
            end
            exp_addr_q.push_back(ADDR_W'(a + i));
            exp_data_q.push_back(words_q[i]);
        end
        frame_q.push_back(csum_ovr >= 0 ? 8'(csum_ovr) : cs);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int guard = 0;
        int gaps = 0;
        while (gap_pct > 0 && gaps < 8 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            gaps++;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL in_ready_stall: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap_pct);
        int guard = 0;
        cap_addr_q.delete();
        cap_data_q.delete();
        done_start = done_cnt;
        foreach (frame_q[i]) send_byte(frame_q[i], gap_pct);
        while (done_cnt == done_start && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", guard);
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_checks++;
        if ({in_ready, wr_en, busy, done, err_csum, err_cmd} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: {in_ready,wr_en,busy,done,err_csum,err_cmd}=%b required 100000",
                     {in_ready, wr_en, busy, done, err_csum, err_cmd});
        end
        n_checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: wr_addr=%h wr_data=%h required 0", wr_addr, wr_data);
        end
    endtask

    task automatic test_single_word();
        words_q.delete();
        words_q.push_back(260'h1);
        make_frame(10'd5, 0, -1);
        run_frame(0);
        n_checks++;
        if (cap_addr_q.size() !== 1 || cap_addr_q[0] !== 10'd5 || cap_data_q[0] !== 260'h1) begin
            n_fail++;
            $display("FAIL single_write: writes=%0d addr=%h data=%h required 1 write addr 005 data 1",
                     cap_addr_q.size(), cap_addr_q.size() ? cap_addr_q[0] : '0,
                     cap_data_q.size() ? cap_data_q[0] : '0);
        end
        n_checks++;
        if (done_cnt - done_start !== 1 || err_csum !== 1'b0 || err_cmd !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: done=%0d err_csum=%b err_cmd=%b busy=%b required 1,0,0,0",
                     done_cnt - done_start, err_csum, err_cmd, busy);
        end
    endtask

    task automatic test_wrap_and_gaps();
        int bad;
        logic [WORD_W-1:0] saved[$];
        words_q.delete();
        for (int i = 0; i < 3; i++) words_q.push_back(rand_word());
        saved = words_q;
        for (int pass = 0; pass < 2; pass++) begin
            words_q = saved;
            make_frame(10'd1022, 1, -1);
            run_frame(pass == 0 ? 0 : 50);
            bad = 0;
            foreach (exp_addr_q[i])
                if (i >= cap_addr_q.size() || cap_addr_q[i] !== exp_addr_q[i] || cap_data_q[i] !== exp_data_q[i])
                    bad++;
            n_checks++;
            if (cap_addr_q.size() !== 3 || bad != 0) begin
                n_fail++;
                $display("FAIL wrap_writes pass%0d: writes=%0d wrong=%0d required 3 writes at 3fe,3ff,000",
                         pass, cap_addr_q.size(), bad);
            end
            if (pass == 0) begin
                gapless_data_q = cap_data_q;
            end else begin
                n_checks++;
                if (cap_data_q != gapless_data_q) begin
                    n_fail++;
                    $display("FAIL gaps_vs_gapless: gapped writes=%0d differ from gapless writes=%0d",
                             cap_data_q.size(), gapless_data_q.size());
                end
            end
            n_checks++;
            if (bubble_viol !== 0 || err_csum !== 1'b0 || done_cnt - done_start !== 1) begin
                n_fail++;
                $display("FAIL wrap_status pass%0d: bubble_viol=%0d err_csum=%b done=%0d required 0,0,1",
                         pass, bubble_viol, err_csum, done_cnt - done_start);
            end
        end
    endtask

    task automatic test_bad_csum();
        words_q.delete();
        words_q.push_back(260'h1);
        make_frame(10'd5, 0, 0);
        run_frame(0);
        n_checks++;
        if (cap_addr_q.size() !== 1 || cap_addr_q[0] !== 10'd5 || cap_data_q[0] !== 260'h1) begin
            n_fail++;
            $display("FAIL badcsum_write: writes=%0d required 1 write at 005", cap_addr_q.size());
        end
        n_checks++;
        if (err_csum !== 1'b1 || done_cnt - done_start !== 1) begin
            n_fail++;
            $display("FAIL badcsum_flag: err_csum=%b done=%0d required 1,1", err_csum, done_cnt - done_start);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err_csum !== 1'b1) begin
            n_fail++;
            $display("FAIL badcsum_sticky: err_csum=%b required 1", err_csum);
        end
        send_byte(CMD_CLEAR, 0);
        @(posedge clk); #1;
        n_checks++;
        if (err_csum !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL badcsum_clear: err_csum=%b busy=%b required 0,0", err_csum, busy);
        end
    endtask

    task automatic test_bad_cmd();
        cap_addr_q.delete();
        done_start = done_cnt;
        send_byte(8'h3C, 0);
        @(posedge clk); #1;
        n_checks++;
        if (err_cmd !== 1'b1 || busy !== 1'b0 || cap_addr_q.size() !== 0 || done_cnt !== done_start) begin
            n_fail++;
            $display("FAIL badcmd_flag: err_cmd=%b busy=%b writes=%0d done=%0d required 1,0,0,0",
                     err_cmd, busy, cap_addr_q.size(), done_cnt - done_start);
        end
        send_byte(CMD_CLEAR, 0);
        @(posedge clk); #1;
        n_checks++;
        if (err_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL badcmd_clear: err_cmd=%b required 0", err_cmd);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h3C, 0);
        words_q.delete();
        words_q.push_back(rand_word());
        make_frame(10'd7, 1, -1);
        cap_addr_q.delete();
        for (int i = 0; i < 24; i++) send_byte(frame_q[i], 0);
        pulse_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cap_addr_q.size() !== 0 || {in_ready, wr_en, busy, done, err_csum, err_cmd} !== 6'b100000
            || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: writes=%0d flags=%b wr_addr=%h required 0,100000,000",
                     cap_addr_q.size(), {in_ready, wr_en, busy, done, err_csum, err_cmd}, wr_addr);
        end
        run_frame(0);
        n_checks++;
        if (cap_addr_q.size() !== 1 || cap_addr_q[0] !== 10'd7 || cap_data_q[0] !== words_q[0] || err_csum !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next: writes=%0d err_csum=%b required 1 write at 007 with no error",
                     cap_addr_q.size(), err_csum);
        end
    endtask

    task automatic test_random_frames();
        int bad, n, corrupt;
        logic [ADDR_W-1:0] a;
        for (int f = 0; f < 4; f++) begin
            n = 1 + $urandom_range(3);
            a = ADDR_W'($urandom);
            corrupt = $urandom_range(1);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back(rand_word());
            make_frame(a, 1, -1);
            if (corrupt != 0) frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'(1 + $urandom_range(254));
            run_frame(25);
            bad = 0;
            foreach (exp_addr_q[i])
                if (i >= cap_addr_q.size() || cap_addr_q[i] !== exp_addr_q[i] || cap_data_q[i] !== exp_data_q[i])
                    bad++;
            n_checks++;
            if (cap_addr_q.size() !== n || bad != 0 || err_csum !== corrupt[0]) begin
                n_fail++;
                $display("FAIL random_frame%0d: writes=%0d wrong=%0d err_csum=%b required %0d,0,%b",
                         f, cap_addr_q.size(), bad, err_csum, n, corrupt[0]);
            end
            send_byte(CMD_CLEAR, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_wrap_and_gaps();
        test_bad_csum();
        test_bad_cmd();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
